// File: rtl/alarm_ring_ctrl.sv
// Alarm sounder sequencer: arms on time mismatch, rings on match, times the ring and snooze.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_ring_ctrl #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              one_second,
  input  logic                              alarm_en,
  input  logic [15:0]                       current_time,
  input  logic [15:0]                       alarm_time,
  input  logic                              stop_button,
  input  logic                              snooze_button,
  output logic                              sound_alarm,
  output logic                              snoozing,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_left
);

  localparam int RW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
  localparam int LW = $clog2(MAX_SNOOZE + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_ARMED,
    S_RINGING
`ifdef ALARM_SNOOZE_EN
    , S_SNOOZE
`endif
  } state_t;

  state_t        r_state, w_next_state;
  logic [RW-1:0] r_ring_cnt;
  logic          r_stop_q;
  logic          w_match, w_stop_press;
  logic          w_ring_clr, w_ring_inc;

  assign w_match      = (current_time == alarm_time);
  assign w_stop_press = stop_button & ~r_stop_q;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS) : 1;
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECONDS - 1);

  logic [SW-1:0] r_snz_cnt;
  logic [LW-1:0] r_snooze_left;
  logic          r_snooze_q;
  logic          w_snooze_press;
  logic          w_snz_clr, w_snz_inc, w_left_load, w_left_dec;

  assign w_snooze_press = snooze_button & ~r_snooze_q;
`else
  logic w_unused_snooze;
  assign w_unused_snooze = snooze_button | (SNOOZE_SECONDS == 0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_stop_q <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_stop_q <= stop_button;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_ring_clr   = 1'b0;
    w_ring_inc   = 1'b0;
`ifdef ALARM_SNOOZE_EN
    w_snz_clr    = 1'b0;
    w_snz_inc    = 1'b0;
    w_left_load  = 1'b0;
    w_left_dec   = 1'b0;
`endif
    if (!alarm_en) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_HOLD;
        // Enabling inside the alarm minute must see a mismatch before it can ring.
        S_HOLD:  if (!w_match) w_next_state = S_ARMED;
        S_ARMED: if (w_match) begin
          w_next_state = S_RINGING;
          w_ring_clr   = 1'b1;
`ifdef ALARM_SNOOZE_EN
          w_left_load  = 1'b1;
`endif
        end
        S_RINGING: begin
          if (w_stop_press) begin
            w_next_state = S_HOLD;
          end
`ifdef ALARM_SNOOZE_EN
          else if (w_snooze_press && (r_snooze_left != '0)) begin
            w_next_state = S_SNOOZE;
            w_left_dec   = 1'b1;
            w_snz_clr    = 1'b1;
          end
`endif
          else if (one_second) begin
            if (r_ring_cnt == RING_LAST) w_next_state = S_HOLD;
            else                         w_ring_inc   = 1'b1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        S_SNOOZE: begin
          if (w_stop_press) begin
            w_next_state = S_HOLD;
          end else if (one_second) begin
            if (r_snz_cnt == SNOOZE_LAST) begin
              w_next_state = S_RINGING;
              w_ring_clr   = 1'b1;
            end else begin
              w_snz_inc = 1'b1;
            end
          end
        end
`endif
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           r_ring_cnt <= '0;
    else if (w_ring_clr) r_ring_cnt <= '0;
    else if (w_ring_inc) r_ring_cnt <= r_ring_cnt + 1'b1;
  end

  assign sound_alarm = (r_state == S_RINGING);

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_snz_cnt     <= '0;
      r_snooze_left <= '0;
      r_snooze_q    <= 1'b0;
    end else begin
      r_snooze_q <= snooze_button;
      if (w_snz_clr)      r_snz_cnt <= '0;
      else if (w_snz_inc) r_snz_cnt <= r_snz_cnt + 1'b1;
      if (w_left_load)     r_snooze_left <= LW'(MAX_SNOOZE);
      else if (w_left_dec) r_snooze_left <= r_snooze_left - 1'b1;
    end
  end

  assign snoozing    = (r_state == S_SNOOZE);
  assign snooze_left = r_snooze_left;
`else
  assign snoozing    = 1'b0;
  assign snooze_left = '0;
`endif

endmodule
